vga_vertical_edge: RTL and testbench

Streaming VGA stage placed directly downstream of the colour filter and before the VGA DAC outputs. It converts each active pixel to grayscale, keeps the previous active line in a one-line buffer, and outputs either pass-through, grayscale, vertical-gradient magnitude, or thresholded edges. It also reports the number of edge pixels in the last complete frame. All sync and blank signals are delayed to stay aligned with the pixel data.

---
 rtl/vga_vertical_edge.sv | 160 ++++++++++++++++
 tb/tb_vga_vertical_edge.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vga_vertical_edge.sv
// Streaming VGA vertical-edge stage: grayscale, one-line buffer, |gray - line above|,
// mode select and per-frame edge count, with a fixed two-cycle latency on every output.
module vga_vertical_edge #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        VGA_CLK,
  input  logic        reset_n,
  input  logic [7:0]  iVGA_R,
  input  logic [7:0]  iVGA_G,
  input  logic [7:0]  iVGA_B,
  input  logic        iVGA_HS,
  input  logic        iVGA_VS,
  input  logic        iVGA_SYNC_N,
  input  logic        iVGA_BLANK_N,
  input  logic [1:0]  mode,
  input  logic [7:0]  thresh,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_SYNC_N,
  output logic        oVGA_BLANK_N,
  output logic [19:0] edge_count
);

  localparam int STAGES = 2;
  localparam int XW     = $clog2(WIDTH + 1);
  localparam int AW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW     = $clog2(HEIGHT + 1);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       sync_n;
  } pix_t;

  pix_t            s1;
  logic [STAGES:1] vld_pipe;
  logic [7:0]      gray1, rd1, thresh1;
  logic [1:0]      mode1;
  logic [XW-1:0]   x_cnt, x1;
  logic [YW-1:0]   y_cnt, y1;
  logic            vs_seen;
  logic [19:0]     cnt;
  logic [7:0]      line_mem [WIDTH];

  logic [9:0]      gray_sum;
  logic [AW-1:0]   rd_addr;
  logic            blank_fall, vs_fall, vs_rise;
  logic            in_range, wr_en, is_edge;
  logic [7:0]      diff, mag, sel_r, sel_g, sel_b;
  logic [19:0]     cnt_next;

  assign gray_sum   = {2'b00, iVGA_R} + {1'b0, iVGA_G, 1'b0} + {2'b00, iVGA_B};
  assign blank_fall = vld_pipe[1] & ~iVGA_BLANK_N;
  assign vs_fall    = s1.vs & ~iVGA_VS;
  assign vs_rise    = ~s1.vs & iVGA_VS;
  assign rd_addr    = (x_cnt < XW'(WIDTH)) ? x_cnt[AW-1:0] : '0;

  // Column / row position of the pixel currently on the inputs
  always_ff @(posedge VGA_CLK) begin
    if (!reset_n)                      x_cnt <= '0;
    else if (!iVGA_BLANK_N)            x_cnt <= '0;
    else if (x_cnt != XW'(WIDTH))      x_cnt <= x_cnt + 1'b1;
  end

  always_ff @(posedge VGA_CLK) begin
    if (!reset_n)                                   y_cnt <= '0;
    else if (!iVGA_VS)                              y_cnt <= '0;
    else if (blank_fall && y_cnt != YW'(HEIGHT))    y_cnt <= y_cnt + 1'b1;
  end

  // After reset the buffer is stale; edges stay off until a full VS low period has passed
  always_ff @(posedge VGA_CLK) begin
    if (!reset_n)     vs_seen <= 1'b0;
    else if (vs_rise) vs_seen <= 1'b1;
  end

  // Read at x(t) lands with stage 1; write of x(t) happens a cycle later, so
  // read and write addresses never collide within a line.
  assign wr_en = reset_n & vld_pipe[1] & in_range;

  always_ff @(posedge VGA_CLK) begin
    rd1 <= line_mem[rd_addr];
    if (wr_en) line_mem[x1[AW-1:0]] <= gray1;
  end

  // Stage 2 datapath
  assign in_range = (x1 < XW'(WIDTH));
  assign diff     = (gray1 >= rd1) ? (gray1 - rd1) : (rd1 - gray1);
  assign mag      = (in_range && vs_seen && y1 != '0) ? diff : 8'd0;
  assign is_edge  = vld_pipe[1] & in_range & vs_seen & (mag >= thresh1);

  always_comb begin
    sel_r = s1.r;
    sel_g = s1.g;
    sel_b = s1.b;
    case (mode1)
      2'd1:    begin sel_r = gray1; sel_g = gray1; sel_b = gray1; end
      2'd2:    begin sel_r = mag;   sel_g = mag;   sel_b = mag;   end
      2'd3:    begin sel_r = {8{is_edge}}; sel_g = {8{is_edge}}; sel_b = {8{is_edge}}; end
      default: ;
    endcase
  end

  always_ff @(posedge VGA_CLK) begin
    if (!reset_n) begin
      s1          <= '{r: 8'd0, g: 8'd0, b: 8'd0, hs: 1'b1, vs: 1'b1, sync_n: 1'b0};
      vld_pipe    <= '0;
      gray1       <= '0;
      x1          <= '0;
      y1          <= '0;
      mode1       <= '0;
      thresh1     <= '0;
      oVGA_R      <= '0;
      oVGA_G      <= '0;
      oVGA_B      <= '0;
      oVGA_HS     <= 1'b1;
      oVGA_VS     <= 1'b1;
      oVGA_SYNC_N <= 1'b0;
    end else begin
      s1          <= '{r: iVGA_R, g: iVGA_G, b: iVGA_B, hs: iVGA_HS, vs: iVGA_VS, sync_n: iVGA_SYNC_N};
      vld_pipe    <= {vld_pipe[STAGES-1:1], iVGA_BLANK_N};
      gray1       <= gray_sum[9:2];
      x1          <= x_cnt;
      y1          <= y_cnt;
      mode1       <= mode;
      thresh1     <= thresh;
      oVGA_R      <= vld_pipe[1] ? sel_r : 8'd0;
      oVGA_G      <= vld_pipe[1] ? sel_g : 8'd0;
      oVGA_B      <= vld_pipe[1] ? sel_b : 8'd0;
      oVGA_HS     <= s1.hs;
      oVGA_VS     <= s1.vs;
      oVGA_SYNC_N <= s1.sync_n;
    end
  end

  assign oVGA_BLANK_N = vld_pipe[STAGES];

  // Frame edge counter; a pixel counted on the VS falling cycle goes into the latched value
  assign cnt_next = cnt + {19'd0, (is_edge && cnt != 20'hFFFFF)};

  always_ff @(posedge VGA_CLK) begin
    if (!reset_n) begin
      cnt        <= '0;
      edge_count <= '0;
    end else if (vs_fall) begin
      edge_count <= cnt_next;
      cnt        <= '0;
    end else begin
      cnt        <= cnt_next;
    end
  end

endmodule

// File: tb/tb_vga_vertical_edge.sv
// Directed bench for vga_vertical_edge: vector table for per-pixel modes plus
// whole-frame sequences; expected pixels are derived from the frame pattern by hand rules.
module tb_vga_vertical_edge;
  localparam int W = 10;
  localparam int H = 10;

  logic        VGA_CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  iVGA_R = '0, iVGA_G = '0, iVGA_B = '0;
  logic        iVGA_HS = 1'b1, iVGA_VS = 1'b1, iVGA_SYNC_N = 1'b0, iVGA_BLANK_N = 1'b0;
  logic [1:0]  mode = '0;
  logic [7:0]  thresh = '0;
  logic [7:0]  oVGA_R, oVGA_G, oVGA_B;
  logic        oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N;
  logic [19:0] edge_count;

  always #5 VGA_CLK = ~VGA_CLK;

  vga_vertical_edge #(.WIDTH(W), .HEIGHT(H)) dut (
    .VGA_CLK(VGA_CLK), .reset_n(reset_n),
    .iVGA_R(iVGA_R), .iVGA_G(iVGA_G), .iVGA_B(iVGA_B),
    .iVGA_HS(iVGA_HS), .iVGA_VS(iVGA_VS), .iVGA_SYNC_N(iVGA_SYNC_N), .iVGA_BLANK_N(iVGA_BLANK_N),
    .mode(mode), .thresh(thresh),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
    .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS), .oVGA_SYNC_N(oVGA_SYNC_N), .oVGA_BLANK_N(oVGA_BLANK_N),
    .edge_count(edge_count)
  );

  typedef struct {
    logic [7:0] r, g, b;
    logic       hs, vs, sn, bl;
    logic [1:0] md;
    logic [7:0] th;
    logic [7:0] er, eg, eb;
    int         tag;
  } vec_t;

  typedef struct {
    logic [7:0] r, g, b;
    logic       hs, vs, sn, bl;
  } out_t;

  typedef struct {
    logic [1:0] md;
    logic [7:0] th, r, g, b, er, eg, eb;
  } tv_t;

  int         total = 0;
  int         bad = 0;
  logic [1:0] cur_mode = '0;
  logic [7:0] cur_th = '0;
  vec_t       iq[$];
  out_t       oq[$];
  tv_t        tv[10];
  string      tname[7];

  task automatic step(input vec_t v);
    out_t o;
    iVGA_R = v.r; iVGA_G = v.g; iVGA_B = v.b;
    iVGA_HS = v.hs; iVGA_VS = v.vs; iVGA_SYNC_N = v.sn; iVGA_BLANK_N = v.bl;
    mode = v.md; thresh = v.th;
    @(posedge VGA_CLK); #1;
    o.r = oVGA_R; o.g = oVGA_G; o.b = oVGA_B;
    o.hs = oVGA_HS; o.vs = oVGA_VS; o.sn = oVGA_SYNC_N; o.bl = oVGA_BLANK_N;
    iq.push_back(v);
    oq.push_back(o);
  endtask

  task automatic blank_cyc(input logic hs, input logic vs, input int tag);
    vec_t v;
    v.r = 0; v.g = 0; v.b = 0; v.hs = hs; v.vs = vs; v.sn = 1'($urandom); v.bl = 1'b0;
    v.md = cur_mode; v.th = cur_th; v.er = 0; v.eg = 0; v.eb = 0; v.tag = tag;
    step(v);
  endtask

  task automatic pixel(input logic [7:0] r, g, b, er, eg, eb, input int tag);
    vec_t v;
    v.r = r; v.g = g; v.b = b; v.hs = 1'b1; v.vs = 1'b1; v.sn = 1'($urandom); v.bl = 1'b1;
    v.md = cur_mode; v.th = cur_th; v.er = er; v.eg = eg; v.eb = eb; v.tag = tag;
    step(v);
  endtask

  task automatic line_tail(input int tag);
    for (int k = 0; k < 4; k++) blank_cyc(k != 1, 1'b1, tag);
  endtask

  task automatic vsync(input int tag);
    for (int k = 0; k < 3; k++) blank_cyc(1'b1, 1'b0, tag);
    for (int k = 0; k < 2; k++) blank_cyc(1'b1, 1'b1, tag);
  endtask

  // Tags: 2 pass, 3 gray, 4 vedge, 5 thresh, 6 mode switch
  task automatic frame(input int tag, input int len);
    logic [7:0] r, g, b, e;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < len; x++) begin
        case (tag)
          2: begin r = 8'(x); g = 8'(y); b = 8'(x + y); pixel(r, g, b, r, g, b, tag); end
          3: pixel(8'd200, 8'd100, 8'd40, 8'd110, 8'd110, 8'd110, tag);
          4: begin
            r = (y >= 5) ? 8'd255 : 8'd0;
            e = (y == 5) ? 8'd255 : 8'd0;
            pixel(r, r, r, e, e, e, tag);
          end
          5: begin
            r = y[0] ? 8'd200 : 8'd0;
            e = (y >= 1 && x < W) ? 8'd255 : 8'd0;
            pixel(r, r, r, e, e, e, tag);
          end
          default: begin
            if (y == 3 && x == 5) cur_mode = 2'd0;
            r = 8'(x * 20); g = 8'(x * 10); b = 8'd5;
            if (cur_mode == 2'd0) pixel(r, g, b, r, g, b, tag);
            else                  pixel(r, g, b, 8'd0, 8'd0, 8'd0, tag);
          end
        endcase
      end
      line_tail(tag);
    end
    blank_cyc(1'b1, 1'b1, tag);
    blank_cyc(1'b1, 1'b1, tag);
  endtask

  task automatic check_ec(input logic [19:0] exp, input string nm);
    total++;
    if (edge_count !== exp) begin
      bad++;
      $display("FAIL edge_count_%s got=%0d want=%0d", nm, edge_count, exp);
    end
  endtask

  initial begin
    tname = '{"reset", "table", "pass", "gray", "vedge", "thresh", "switch"};
    //         md    th      r       g       b       er      eg      eb
    tv[0] = '{2'd0, 8'd0, 8'd12,  8'd34,  8'd56,  8'd12,  8'd34,  8'd56};
    tv[1] = '{2'd1, 8'd0, 8'd200, 8'd100, 8'd40,  8'd110, 8'd110, 8'd110};
    tv[2] = '{2'd1, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    tv[3] = '{2'd1, 8'd0, 8'd3,   8'd1,   8'd0,   8'd1,   8'd1,   8'd1};
    tv[4] = '{2'd1, 8'd0, 8'd1,   8'd0,   8'd2,   8'd0,   8'd0,   8'd0};
    tv[5] = '{2'd2, 8'd0, 8'd255, 8'd255, 8'd255, 8'd0,   8'd0,   8'd0};
    tv[6] = '{2'd3, 8'd1, 8'd255, 8'd0,   8'd255, 8'd0,   8'd0,   8'd0};
    tv[7] = '{2'd0, 8'd0, 8'd255, 8'd0,   8'd128, 8'd255, 8'd0,   8'd128};
    tv[8] = '{2'd1, 8'd0, 8'd0,   8'd255, 8'd0,   8'd127, 8'd127, 8'd127};
    tv[9] = '{2'd1, 8'd0, 8'd255, 8'd0,   8'd255, 8'd127, 8'd127, 8'd127};

    // Reset with random inputs
    for (int i = 0; i < 6; i++) begin
      iVGA_R = 8'($urandom); iVGA_G = 8'($urandom); iVGA_B = 8'($urandom);
      iVGA_HS = 1'($urandom); iVGA_VS = 1'($urandom); iVGA_SYNC_N = 1'($urandom);
      iVGA_BLANK_N = 1'($urandom); mode = 2'($urandom); thresh = 8'($urandom);
      @(posedge VGA_CLK); #1;
      total++;
      if ({oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N, edge_count} !==
          {24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 20'd0}) begin
        bad++;
        $display("FAIL reset[%0d] got rgb=%h hs=%b vs=%b sn=%b bl=%b ec=%0d want rgb=0 hs=1 vs=1 sn=0 bl=0 ec=0",
                 i, {oVGA_R, oVGA_G, oVGA_B}, oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N, edge_count);
      end
    end
    reset_n = 1'b1;

    vsync(1);
    for (int i = 0; i < 10; i++) begin
      cur_mode = tv[i].md; cur_th = tv[i].th;
      pixel(tv[i].r, tv[i].g, tv[i].b, tv[i].er, tv[i].eg, tv[i].eb, 1);
    end
    line_tail(1);

    cur_mode = 2'd0; cur_th = 8'd255;
    vsync(2); frame(2, W); vsync(2); check_ec(20'd0, "pass");
    cur_mode = 2'd1;
    frame(3, W); vsync(3); check_ec(20'd0, "gray");
    cur_mode = 2'd2; cur_th = 8'd128;
    frame(4, W); vsync(4); check_ec(20'd10, "vedge1");
    frame(4, W); vsync(4); check_ec(20'd10, "vedge2");
    cur_mode = 2'd3;
    frame(5, W + 2); vsync(5); check_ec(20'd90, "thresh");
    cur_mode = 2'd2; cur_th = 8'd255;
    frame(6, W); vsync(6); check_ec(20'd0, "switch");
    for (int k = 0; k < 3; k++) blank_cyc(1'b1, 1'b1, 6);

    // Output sampled after edge j+1 belongs to the input driven in cycle j
    for (int j = 0; j + 1 < iq.size(); j++) begin
      total++;
      if ({oq[j+1].r, oq[j+1].g, oq[j+1].b, oq[j+1].hs, oq[j+1].vs, oq[j+1].sn, oq[j+1].bl} !==
          {iq[j].er, iq[j].eg, iq[j].eb, iq[j].hs, iq[j].vs, iq[j].sn, iq[j].bl}) begin
        bad++;
        $display("FAIL %s[%0d] got rgb=%h hs=%b vs=%b sn=%b bl=%b want rgb=%h hs=%b vs=%b sn=%b bl=%b",
                 tname[iq[j].tag], j, {oq[j+1].r, oq[j+1].g, oq[j+1].b}, oq[j+1].hs, oq[j+1].vs,
                 oq[j+1].sn, oq[j+1].bl, {iq[j].er, iq[j].eg, iq[j].eb}, iq[j].hs, iq[j].vs,
                 iq[j].sn, iq[j].bl);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
